// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester-side and controller-side signals of the
// two-port memory arbiter. The arbiter connects through the slave modport;
// the environment (requesters plus memory controller) uses master.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDRESS_SIZE = 23,
  parameter int unsigned DATA_SIZE    = 16
);
  // requester side, bit/slice i belongs to requester i
  logic [1:0]                  req;
  logic [1:0]                  op;
  logic [1:0]                  len;
  logic [1:0]                  cs;
  logic [2*ADDRESS_SIZE-1:0]   addr;
  logic [2*DATA_SIZE-1:0]      wdata;
  logic [1:0]                  gnt;
  logic [1:0]                  ack;
  logic [1:0]                  err;
  logic [DATA_SIZE-1:0]        rdata;

  // memory controller side
  logic                        mc_start;
  logic [ADDRESS_SIZE-1:0]     mc_addr;
  logic [DATA_SIZE-1:0]        mc_wdata;
  logic                        mc_op;
  logic                        mc_len;
  logic                        mc_cs;
  logic [DATA_SIZE-1:0]        mc_rdata;
  logic                        mc_done;

  modport slave (
    input  req, op, len, cs, addr, wdata, mc_rdata, mc_done,
    output gnt, ack, err, rdata, mc_start, mc_addr, mc_wdata, mc_op, mc_len, mc_cs
  );

  modport master (
    output req, op, len, cs, addr, wdata, mc_rdata, mc_done,
    input  gnt, ack, err, rdata, mc_start, mc_addr, mc_wdata, mc_op, mc_len, mc_cs
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester round-robin arbiter in front of the
// RAM/ROM memory controller. Requester 0 is the CPU, requester 1 DMA/video.
// One transaction in flight; command latched, single start pulse issued,
// completion returned as rdata + one-cycle ack to the granted requester.
// Optional: define ARB_TIMEOUT_EN to enable the WAIT watchdog, which aborts
// a transaction after TIMEOUT_CYCLES with ack + err and rdata cleared.
module mem_port_arbiter #(
  parameter int unsigned ADDRESS_SIZE   = 23,
  parameter int unsigned DATA_SIZE      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned CNT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arbState;

  arbState state;
  arbState stateNext;

  logic                    lastGnt;
  logic                    lastGntNext;
  logic                    sel;
  logic [1:0]              gntQ;
  logic [1:0]              gntNext;
  logic [1:0]              ackQ;
  logic [1:0]              ackNext;
  logic [DATA_SIZE-1:0]    rdataQ;
  logic [DATA_SIZE-1:0]    rdataNext;
  logic                    startQ;
  logic                    startNext;
  logic [ADDRESS_SIZE-1:0] addrQ;
  logic [ADDRESS_SIZE-1:0] addrNext;
  logic [DATA_SIZE-1:0]    wdataQ;
  logic [DATA_SIZE-1:0]    wdataNext;
  logic                    opQ;
  logic                    opNext;
  logic                    lenQ;
  logic                    lenNext;
  logic                    csQ;
  logic                    csNext;

`ifdef ARB_TIMEOUT_EN
  logic [1:0]              errQ;
  logic [1:0]              errNext;
  logic [CNT_WIDTH-1:0]    waitCnt;
  logic                    timeoutHit;

  // Watchdog: held at zero outside WAIT, counts WAIT cycles without completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waitCnt <= '0;
    end else if (state != WAIT) begin
      waitCnt <= '0;
    end else if (!bus.mc_done) begin
      waitCnt <= waitCnt + CNT_WIDTH'(1);
    end
  end

  assign timeoutHit = (waitCnt == CNT_WIDTH'(TIMEOUT_CYCLES));
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and next-output logic; every register holds unless a state acts
  always_comb begin
    stateNext   = state;
    lastGntNext = lastGnt;
    gntNext     = gntQ;
    ackNext     = ackQ;
    rdataNext   = rdataQ;
    startNext   = startQ;
    addrNext    = addrQ;
    wdataNext   = wdataQ;
    opNext      = opQ;
    lenNext     = lenQ;
    csNext      = csQ;
    sel         = 1'b0;
`ifdef ARB_TIMEOUT_EN
    errNext     = errQ;
`endif

    case (state)
      IDLE: begin
        if (bus.req != 2'b00) begin
          // both pending: the one not served last wins; otherwise the only one
          sel         = (bus.req == 2'b11) ? ~lastGnt : bus.req[1];
          addrNext    = sel ? bus.addr[ADDRESS_SIZE +: ADDRESS_SIZE]
                            : bus.addr[0 +: ADDRESS_SIZE];
          wdataNext   = sel ? bus.wdata[DATA_SIZE +: DATA_SIZE]
                            : bus.wdata[0 +: DATA_SIZE];
          opNext      = sel ? bus.op[1]  : bus.op[0];
          lenNext     = sel ? bus.len[1] : bus.len[0];
          csNext      = sel ? bus.cs[1]  : bus.cs[0];
          gntNext     = sel ? 2'b10 : 2'b01;
          startNext   = 1'b1;
          lastGntNext = sel;
          stateNext   = ISSUE;
        end
      end

      ISSUE: begin
        startNext = 1'b0;
        stateNext = WAIT;
      end

      WAIT: begin
        if (bus.mc_done) begin
          if (!opQ) begin
            rdataNext = bus.mc_rdata;
          end
          ackNext   = gntQ;
          gntNext   = 2'b00;
          stateNext = RESP;
        end
`ifdef ARB_TIMEOUT_EN
        else if (timeoutHit) begin
          rdataNext = '0;
          ackNext   = gntQ;
          errNext   = gntQ;
          gntNext   = 2'b00;
          stateNext = RESP;
        end
`endif
      end

      RESP: begin
        ackNext   = 2'b00;
`ifdef ARB_TIMEOUT_EN
        errNext   = 2'b00;
`endif
        stateNext = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Output and command registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastGnt <= 1'b1;
      gntQ    <= 2'b00;
      ackQ    <= 2'b00;
      rdataQ  <= '0;
      startQ  <= 1'b0;
      addrQ   <= '0;
      wdataQ  <= '0;
      opQ     <= 1'b0;
      lenQ    <= 1'b0;
      csQ     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      errQ    <= 2'b00;
`endif
    end else begin
      lastGnt <= lastGntNext;
      gntQ    <= gntNext;
      ackQ    <= ackNext;
      rdataQ  <= rdataNext;
      startQ  <= startNext;
      addrQ   <= addrNext;
      wdataQ  <= wdataNext;
      opQ     <= opNext;
      lenQ    <= lenNext;
      csQ     <= csNext;
`ifdef ARB_TIMEOUT_EN
      errQ    <= errNext;
`endif
    end
  end

  assign bus.gnt      = gntQ;
  assign bus.ack      = ackQ;
  assign bus.rdata    = rdataQ;
  assign bus.mc_start = startQ;
  assign bus.mc_addr  = addrQ;
  assign bus.mc_wdata = wdataQ;
  assign bus.mc_op    = opQ;
  assign bus.mc_len   = lenQ;
  assign bus.mc_cs    = csQ;
`ifdef ARB_TIMEOUT_EN
  assign bus.err      = errQ;
`else
  assign bus.err      = 2'b00;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a scoreboard. The main process
// pushes expected commands/responses; a negedge monitor pops and compares
// whenever the DUT issues mc_start or pulses ack. A small controller model
// answers mc_start after a programmable latency.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 23;
  localparam int unsigned DW = 16;

  typedef struct {
    logic          g;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          op;
    logic          len;
    logic          cs;
  } cmdT;

  typedef struct {
    logic [1:0]    ack;
    logic [DW-1:0] rdata;
    logic [1:0]    err;
  } respT;

  logic clk;
  logic rst;
  mem_port_arbiter_if #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW)) bus ();

  mem_port_arbiter #(
    .ADDRESS_SIZE(AW),
    .DATA_SIZE(DW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  cmdT  cmdQ[$];
  respT respQ[$];
  int   total = 0;
  int   bad = 0;
  int   startCnt = 0;
  int   ackCnt = 0;

  // controller model controls
  logic          ctrlAuto = 1'b0;
  int            ctrlLat = 1;
  logic [DW-1:0] ctrlData = '0;
  logic          forceDone = 1'b0;
  logic          pending = 1'b0;
  int            cntdn = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Controller: pulses mc_done ctrlLat negedges after seeing mc_start, or on forceDone
  always @(negedge clk) begin
    bus.mc_done = 1'b0;
    if (rst) begin
      pending = 1'b0;
    end else if (forceDone) begin
      bus.mc_done  = 1'b1;
      bus.mc_rdata = ctrlData;
    end else if (pending) begin
      if (cntdn == 0) begin
        bus.mc_done  = 1'b1;
        bus.mc_rdata = ctrlData;
        pending      = 1'b0;
      end else begin
        cntdn--;
      end
    end else if (ctrlAuto && bus.mc_start) begin
      pending = 1'b1;
      cntdn   = ctrlLat - 1;
    end
  end

  // Monitor: scoreboard pops on mc_start and on ack
  always @(negedge clk) begin
    cmdT  c;
    respT r;
    if (!rst) begin
      chk("gnt_not_both", 64'(bus.gnt == 2'b11), 64'd0);
      if (bus.ack == 2'b00) chk("err_without_ack", 64'(bus.err), 64'd0);
      if (bus.mc_start) begin
        startCnt++;
        if (cmdQ.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_start: addr %h", bus.mc_addr);
        end else begin
          c = cmdQ.pop_front();
          chk("start_gnt",   64'(bus.gnt), c.g ? 64'd2 : 64'd1);
          chk("start_addr",  64'(bus.mc_addr), 64'(c.addr));
          chk("start_wdata", 64'(bus.mc_wdata), 64'(c.wdata));
          chk("start_sel",   64'({bus.mc_op, bus.mc_len, bus.mc_cs}), 64'({c.op, c.len, c.cs}));
        end
      end
      if (bus.ack != 2'b00) begin
        ackCnt++;
        if (respQ.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ack: ack %b", bus.ack);
        end else begin
          r = respQ.pop_front();
          chk("ack_value",  64'(bus.ack), 64'(r.ack));
          chk("ack_rdata",  64'(bus.rdata), 64'(r.rdata));
          chk("ack_err",    64'(bus.err), 64'(r.err));
          chk("ack_gnt_lo", 64'(bus.gnt), 64'd0);
        end
      end
    end
  end

  task automatic setPort(input int i, input logic o, input logic l, input logic c,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.op[i]             = o;
    bus.len[i]            = l;
    bus.cs[i]             = c;
    bus.addr[i*AW +: AW]  = a;
    bus.wdata[i*DW +: DW] = d;
  endtask

  task automatic expectTxn(input logic g, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic o, input logic l, input logic c,
                           input logic [DW-1:0] rd, input logic [1:0] er);
    cmdT  cm;
    respT rp;
    cm.g = g; cm.addr = a; cm.wdata = d; cm.op = o; cm.len = l; cm.cs = c;
    rp.ack = g ? 2'b10 : 2'b01; rp.rdata = rd; rp.err = er;
    cmdQ.push_back(cm);
    respQ.push_back(rp);
  endtask

  task automatic waitAck(input string name, input int maxCyc);
    for (int k = 0; k < maxCyc; k++) begin
      @(negedge clk);
      if (bus.ack != 2'b00) return;
    end
    total++; bad++;
    $display("FAIL %s: no ack within %0d cycles", name, maxCyc);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulseDone(input logic [DW-1:0] d);
    ctrlData = d;
    @(posedge clk);
    forceDone = 1'b1;
    @(posedge clk);
    forceDone = 1'b0;
  endtask

  initial begin
    int s0;
    int a0;
    int badCycles;
    rst     = 1'b1;
    bus.req = 2'b00;
    bus.op = '0; bus.len = '0; bus.cs = '0; bus.addr = '0; bus.wdata = '0;
    repeat (2) @(negedge clk);
    chk("reset_gnt",   64'(bus.gnt), 64'd0);
    chk("reset_ack",   64'(bus.ack), 64'd0);
    chk("reset_start", 64'(bus.mc_start), 64'd0);
    chk("reset_cmd",   64'({bus.mc_addr, bus.mc_wdata, bus.mc_op, bus.mc_len, bus.mc_cs}), 64'd0);
    chk("reset_rdata", 64'(bus.rdata), 64'd0);
    chk("reset_err",   64'(bus.err), 64'd0);
    rst = 1'b0;

    // t1: single read from requester 0, controller answers 3 cycles after start
    ctrlAuto = 1'b1; ctrlLat = 3; ctrlData = 16'hBEEF;
    setPort(0, 1'b0, 1'b1, 1'b1, 23'h000123, 16'h0000);
    expectTxn(1'b0, 23'h000123, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hBEEF, 2'b00);
    @(negedge clk);
    bus.req = 2'b01;
    @(negedge clk);
    chk("t1_start_latency", 64'(bus.mc_start), 64'd1);
    chk("t1_gnt", 64'(bus.gnt), 64'd1);
    waitAck("t1_ack", 20);
    bus.req = 2'b00;
    @(negedge clk);
    chk("t1_ack_one_cycle", 64'(bus.ack), 64'd0);
    chk("t1_gnt_released", 64'(bus.gnt), 64'd0);
    chk("t1_rdata_hold", 64'(bus.rdata), 64'hBEEF);

    // t2: both held through 4 writes, grants alternate starting with 0
    doReset();
    ctrlLat = 2;
    setPort(0, 1'b1, 1'b1, 1'b1, 23'h000010, 16'h1111);
    setPort(1, 1'b1, 1'b0, 1'b0, 23'h000020, 16'h2222);
    for (int t = 0; t < 4; t++) begin
      if (t % 2 == 0) expectTxn(1'b0, 23'h000010, 16'h1111, 1'b1, 1'b1, 1'b1, 16'h0000, 2'b00);
      else            expectTxn(1'b1, 23'h000020, 16'h2222, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b00);
    end
    @(negedge clk);
    bus.req = 2'b11;
    for (int t = 0; t < 4; t++) waitAck("t2_ack", 20);
    bus.req = 2'b00;

    // t3: req0 dropped one cycle after gnt; max address; ack still pulses once
    ctrlLat = 5; ctrlData = 16'h1234;
    setPort(0, 1'b0, 1'b0, 1'b1, 23'h7FFFFF, 16'h0000);
    expectTxn(1'b0, 23'h7FFFFF, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234, 2'b00);
    @(negedge clk);
    bus.req = 2'b01;
    @(negedge clk);
    @(negedge clk);
    bus.req = 2'b00;
    waitAck("t3_ack", 20);
    s0 = startCnt;
    repeat (10) @(negedge clk);
    chk("t3_no_extra_start", 64'(startCnt), 64'(s0));

    // t4: reset in WAIT with completion pending, then a fresh request from 1
    ctrlAuto = 1'b0;
    setPort(1, 1'b0, 1'b1, 1'b0, 23'h000055, 16'h0000);
    cmdQ.push_back('{g: 1'b1, addr: 23'h000055, wdata: 16'h0000, op: 1'b0, len: 1'b1, cs: 1'b0});
    bus.req = 2'b10;
    repeat (3) @(negedge clk);
    bus.req = 2'b00;
    rst = 1'b1;
    #1;
    chk("t4_rst_gnt",   64'(bus.gnt), 64'd0);
    chk("t4_rst_start", 64'(bus.mc_start), 64'd0);
    chk("t4_rst_cmd",   64'({bus.mc_addr, bus.mc_wdata, bus.mc_op, bus.mc_len, bus.mc_cs}), 64'd0);
    chk("t4_rst_rdata", 64'(bus.rdata), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    a0 = ackCnt;
    pulseDone(16'hDEAD);
    repeat (5) @(negedge clk);
    chk("t4_stale_done_no_ack", 64'(ackCnt), 64'(a0));
    ctrlAuto = 1'b1; ctrlLat = 1; ctrlData = 16'hA5A5;
    expectTxn(1'b1, 23'h000055, 16'h0000, 1'b0, 1'b1, 1'b0, 16'hA5A5, 2'b00);
    bus.req = 2'b10;
    @(negedge clk);
    chk("t4_start_latency", 64'(bus.mc_start), 64'd1);
    chk("t4_gnt", 64'(bus.gnt), 64'd2);
    waitAck("t4_ack", 20);
    bus.req = 2'b00;

`ifdef ARB_TIMEOUT_EN
    // t5: controller never completes; watchdog aborts 9 cycles after WAIT entry
    ctrlAuto = 1'b0;
    setPort(1, 1'b0, 1'b1, 1'b1, 23'h000042, 16'h0000);
    expectTxn(1'b1, 23'h000042, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 2'b10);
    @(negedge clk);
    bus.req = 2'b10;
    @(negedge clk);
    chk("t5_start", 64'(bus.mc_start), 64'd1);
    bus.req = 2'b00;
    s0 = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      s0++;
      if (bus.ack != 2'b00) break;
    end
    chk("t5_timeout_latency", 64'(s0), 64'd10);
    @(negedge clk);
    chk("t5_err_cleared", 64'(bus.err), 64'd0);
`else
    // t6: completion withheld 1000 cycles; gnt held, no err, ack on late done
    ctrlAuto = 1'b0;
    setPort(0, 1'b1, 1'b1, 1'b0, 23'h000777, 16'hCAFE);
    expectTxn(1'b0, 23'h000777, 16'hCAFE, 1'b1, 1'b1, 1'b0, 16'hA5A5, 2'b00);
    @(negedge clk);
    bus.req = 2'b01;
    @(negedge clk);
    badCycles = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bus.gnt !== 2'b01 || bus.err !== 2'b00 || bus.ack !== 2'b00) badCycles++;
    end
    chk("t6_gnt_held", 64'(badCycles), 64'd0);
    pulseDone(16'h7777);
    waitAck("t6_ack", 5);
    bus.req = 2'b00;
`endif

    repeat (5) @(negedge clk);
    chk("cmd_queue_empty",  64'(cmdQ.size()), 64'd0);
    chk("resp_queue_empty", 64'(respQ.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
